alu_reservation_station: RTL and testbench

- Tomasulo reservation-station bank for the ALU functional unit. It sits directly downstream of the common data bus (CDB) and upstream of the ALU.
- It accepts decoded ALU ops from the issue stage, holding each as a value or as a tag per operand.
- It snoops the CDB to capture operands as they are produced.
- It dispatches the oldest fully-ready entry to the ALU each cycle.

---
 rtl/alu_reservation_station_pkg.sv | 43 ++++
 rtl/rs_age_select.sv | 23 ++
 rtl/alu_reservation_station.sv | 153 +++++++++++++++
 tb/tb_alu_reservation_station.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: ALU opcodes, ROB tags,
// the common data bus beat and the per-entry station record.
package alu_reservation_station_pkg;

  typedef logic [2:0] lc3b_rob_tag;

  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
  } lc3b_aluop;

  // One CDB beat: valid, produced value, and the ROB tag that produced it.
  typedef struct packed {
    logic        valid;
    logic [15:0] data;
    lc3b_rob_tag tag;
  } lc3b_cdb;

  // One station entry; each operand is either a value (rdy=1) or a tag.
  typedef struct packed {
    logic        busy;
    lc3b_aluop   aluop;
    lc3b_rob_tag dest_tag;
    logic        j_rdy;
    logic [15:0] j_val;
    lc3b_rob_tag j_tag;
    logic        k_rdy;
    logic [15:0] k_val;
    lc3b_rob_tag k_tag;
  } rs_entry;

  // True when a still-waiting operand is satisfied by the current CDB beat.
  function automatic logic cdb_hit(input logic rdy, input lc3b_rob_tag tag,
                                   input lc3b_cdb bus);
    return !rdy && bus.valid && (bus.tag == tag);
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is
// older than. age[i][j]=1 means entry i is older than entry j.
module rs_age_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]        ready,
  input  logic [N-1:0][N-1:0] age,
  output logic [N-1:0]        grant
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_col
      // older_col[j]=1 when entry j is older than entry gi
      logic [N-1:0] older_col;
      for (gj = 0; gj < N; gj++) begin : g_row
        assign older_col[gj] = age[gj][gi];
      end
      assign grant[gi] = ready[gi] & ~|(ready & older_col);
    end
  endgenerate

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation-station bank: holds issued ops until both operands are
// known (directly or via CDB snoop) and hands the oldest ready one to the ALU.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  lc3b_aluop        issue_aluop,
  input  logic [TAG_W-1:0] issue_dest_tag,
  input  logic             issue_j_rdy,
  input  logic [15:0]      issue_j_val,
  input  logic [TAG_W-1:0] issue_j_tag,
  input  logic             issue_k_rdy,
  input  logic [15:0]      issue_k_val,
  input  logic [TAG_W-1:0] issue_k_tag,
  input  lc3b_cdb          cdb,
  input  logic             fu_ready,
  output logic             disp_valid,
  output lc3b_aluop        disp_aluop,
  output logic [15:0]      disp_a,
  output logic [15:0]      disp_b,
  output logic [TAG_W-1:0] disp_tag
);

  localparam int N = NUM_ENTRIES;

  logic [N-1:0]        busy_vec;
  logic [N-1:0]        ready_vec;
  logic [N-1:0]        grant;
  logic [N-1:0]        free_vec;
  logic [N-1:0]        issue_sel;
  logic [N-1:0][N-1:0] age_mat;
  logic                issue_fire;
  logic                disp_fire;
  rs_entry             new_entry;
  rs_entry             entry_masked [N];
  rs_entry             disp_entry;

  // Free-slot tracking: ready to accept whenever any slot is idle; the new
  // op lands in the lowest-index free slot (isolated lowest set bit).
  assign free_vec    = ~busy_vec;
  assign issue_ready = |free_vec;
  assign issue_sel   = free_vec & (~free_vec + N'(1));
  assign issue_fire  = issue_valid && issue_ready && !flush;
  assign disp_fire   = disp_valid && fu_ready && !flush;

  // Build the incoming entry, picking up an operand broadcast on the CDB
  // in the very cycle it is issued.
  always_comb begin
    new_entry          = '0;
    new_entry.busy     = 1'b1;
    new_entry.aluop    = issue_aluop;
    new_entry.dest_tag = issue_dest_tag;
    new_entry.j_rdy    = issue_j_rdy;
    new_entry.j_val    = issue_j_val;
    new_entry.j_tag    = issue_j_tag;
    new_entry.k_rdy    = issue_k_rdy;
    new_entry.k_val    = issue_k_val;
    new_entry.k_tag    = issue_k_tag;
    if (cdb_hit(issue_j_rdy, issue_j_tag, cdb)) begin
      new_entry.j_rdy = 1'b1;
      new_entry.j_val = cdb.data;
    end
    if (cdb_hit(issue_k_rdy, issue_k_tag, cdb)) begin
      new_entry.k_rdy = 1'b1;
      new_entry.k_val = cdb.data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      rs_entry      entry_q, entry_d;
      logic [N-1:0] age_row_q, age_row_d;

      assign busy_vec[gi]     = entry_q.busy;
      assign ready_vec[gi]    = entry_q.busy & entry_q.j_rdy & entry_q.k_rdy;
      assign age_mat[gi]      = age_row_q;
      assign entry_masked[gi] = grant[gi] ? entry_q : '0;

      // Per-entry next state: CDB capture, dispatch release, issue load,
      // age-row update, and flush clearing everything.
      always_comb begin
        entry_d   = entry_q;
        age_row_d = age_row_q;
        if (entry_q.busy && cdb_hit(entry_q.j_rdy, entry_q.j_tag, cdb)) begin
          entry_d.j_rdy = 1'b1;
          entry_d.j_val = cdb.data;
        end
        if (entry_q.busy && cdb_hit(entry_q.k_rdy, entry_q.k_tag, cdb)) begin
          entry_d.k_rdy = 1'b1;
          entry_d.k_val = cdb.data;
        end
        if (disp_fire && grant[gi]) begin
          entry_d.busy = 1'b0;
        end
        if (issue_fire) begin
          if (issue_sel[gi]) begin
            // newcomer is older than nobody
            entry_d   = new_entry;
            age_row_d = '0;
          end else begin
            // every currently busy entry is older than the newcomer
            age_row_d = (age_row_q & ~issue_sel) | (entry_q.busy ? issue_sel : '0);
          end
        end
        if (flush) begin
          entry_d   = '0;
          age_row_d = '0;
        end
      end

      // Entry and age-row registers with synchronous reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_q   <= '0;
          age_row_q <= '0;
        end else begin
          entry_q   <= entry_d;
          age_row_q <= age_row_d;
        end
      end
    end
  endgenerate

  rs_age_select #(.N(N)) u_age_select (
    .ready (ready_vec),
    .age   (age_mat),
    .grant (grant)
  );

  // One-hot grant makes an OR-reduction of masked entries a clean mux;
  // with no grant every field collapses to zero.
  always_comb begin
    disp_entry = '0;
    for (int i = 0; i < N; i++) begin
      disp_entry = disp_entry | entry_masked[i];
    end
  end

  assign disp_valid = |ready_vec;
  assign disp_aluop = disp_entry.aluop;
  assign disp_a     = disp_entry.j_val;
  assign disp_b     = disp_entry.k_val;
  assign disp_tag   = disp_entry.dest_tag;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for the ALU reservation station: per-scenario tasks
// with inline checks plus a dispatch scoreboard fed at stimulus time.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  lc3b_aluop   issue_aluop;
  logic [2:0]  issue_dest_tag;
  logic        issue_j_rdy;
  logic [15:0] issue_j_val;
  logic [2:0]  issue_j_tag;
  logic        issue_k_rdy;
  logic [15:0] issue_k_val;
  logic [2:0]  issue_k_tag;
  lc3b_cdb     cdb;
  logic        fu_ready;
  logic        disp_valid;
  lc3b_aluop   disp_aluop;
  logic [15:0] disp_a;
  logic [15:0] disp_b;
  logic [2:0]  disp_tag;

  typedef struct {
    lc3b_aluop   op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  alu_reservation_station #(.NUM_ENTRIES(4), .TAG_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_aluop    (issue_aluop),
    .issue_dest_tag (issue_dest_tag),
    .issue_j_rdy    (issue_j_rdy),
    .issue_j_val    (issue_j_val),
    .issue_j_tag    (issue_j_tag),
    .issue_k_rdy    (issue_k_rdy),
    .issue_k_val    (issue_k_val),
    .issue_k_tag    (issue_k_tag),
    .cdb            (cdb),
    .fu_ready       (fu_ready),
    .disp_valid     (disp_valid),
    .disp_aluop     (disp_aluop),
    .disp_a         (disp_a),
    .disp_b         (disp_b),
    .disp_tag       (disp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every completed handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && disp_valid && fu_ready && !flush) begin
      n_compared++;
      if (sb.size() == 0) begin
        n_mismatched++;
        $display("FAIL sb_unexpected: got op=%0d a=%h b=%h tag=%0d, required no dispatch",
                 disp_aluop, disp_a, disp_b, disp_tag);
      end else begin
        mon_e = sb.pop_front();
        if ({disp_aluop, disp_a, disp_b, disp_tag} !== {mon_e.op, mon_e.a, mon_e.b, mon_e.tag}) begin
          n_mismatched++;
          $display("FAIL sb_dispatch: got op=%0d a=%h b=%h tag=%0d, required op=%0d a=%h b=%h tag=%0d",
                   disp_aluop, disp_a, disp_b, disp_tag, mon_e.op, mon_e.a, mon_e.b, mon_e.tag);
        end else begin
          $display("dispatch op=%0d a=%h b=%h tag=%0d", disp_aluop, disp_a, disp_b, disp_tag);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input lc3b_aluop op, input logic [2:0] dest,
                             input logic jr, input logic [15:0] jv, input logic [2:0] jt,
                             input logic kr, input logic [15:0] kv, input logic [2:0] kt);
    issue_valid    = 1'b1;
    issue_aluop    = op;
    issue_dest_tag = dest;
    issue_j_rdy    = jr;
    issue_j_val    = jv;
    issue_j_tag    = jt;
    issue_k_rdy    = kr;
    issue_k_val    = kv;
    issue_k_tag    = kt;
  endtask

  task automatic clear_issue();
    issue_valid    = 1'b0;
    issue_aluop    = alu_add;
    issue_dest_tag = '0;
    issue_j_rdy    = 1'b0;
    issue_j_val    = '0;
    issue_j_tag    = '0;
    issue_k_rdy    = 1'b0;
    issue_k_val    = '0;
    issue_k_tag    = '0;
  endtask

  task automatic push_exp(input lc3b_aluop op, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] tag);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_issue(alu_add, 3'd1, 1'b1, 16'h0001, 3'd0, 1'b1, 16'h0002, 3'd0);
    step();
    clear_issue();
    step();
    rst = 1'b0;
    n_compared++;
    if (issue_ready !== 1'b1) begin
      n_mismatched++;
      $display("FAIL reset_issue_ready: got %b required 1", issue_ready);
    end
    n_compared++;
    if (disp_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_disp_valid: got %b required 0", disp_valid);
    end
    n_compared++;
    if ({disp_aluop, disp_a, disp_b, disp_tag} !== 38'd0) begin
      n_mismatched++;
      $display("FAIL reset_disp_fields: got op=%0d a=%h b=%h tag=%0d required all 0",
               disp_aluop, disp_a, disp_b, disp_tag);
    end
  endtask

  task automatic test_basic_add();
    drive_issue(alu_add, 3'd1, 1'b1, 16'h0005, 3'd0, 1'b1, 16'h0003, 3'd0);
    step();
    clear_issue();
    n_compared++;
    if ({disp_valid, disp_aluop, disp_a, disp_b, disp_tag} !== {1'b1, alu_add, 16'h0005, 16'h0003, 3'd1}) begin
      n_mismatched++;
      $display("FAIL add_present: got v=%b op=%0d a=%h b=%h tag=%0d required v=1 op=0 a=0005 b=0003 tag=1",
               disp_valid, disp_aluop, disp_a, disp_b, disp_tag);
    end
    push_exp(alu_add, 16'h0005, 16'h0003, 3'd1);
    fu_ready = 1'b1;
    step();
    fu_ready = 1'b0;
    n_compared++;
    if (disp_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL add_freed: got disp_valid=%b required 0", disp_valid);
    end
  endtask

  task automatic test_cdb_wakeup();
    drive_issue(alu_and, 3'd3, 1'b0, 16'h0000, 3'd2, 1'b1, 16'h0F0F, 3'd0);
    step();
    clear_issue();
    for (int i = 0; i < 3; i++) begin
      n_compared++;
      if (disp_valid !== 1'b0) begin
        n_mismatched++;
        $display("FAIL wake_waiting_%0d: got disp_valid=%b required 0", i, disp_valid);
      end
      step();
    end
    cdb = '{valid: 1'b1, data: 16'h00FF, tag: 3'd2};
    #1;
    n_compared++;
    if (disp_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL wake_same_cycle: got disp_valid=%b required 0", disp_valid);
    end
    step();
    cdb = '0;
    n_compared++;
    if ({disp_valid, disp_aluop, disp_a, disp_b} !== {1'b1, alu_and, 16'h00FF, 16'h0F0F}) begin
      n_mismatched++;
      $display("FAIL wake_next_cycle: got v=%b op=%0d a=%h b=%h required v=1 op=1 a=00ff b=0f0f",
               disp_valid, disp_aluop, disp_a, disp_b);
    end
    push_exp(alu_and, 16'h00FF, 16'h0F0F, 3'd3);
    fu_ready = 1'b1;
    step();
    fu_ready = 1'b0;
  endtask

  task automatic test_issue_bypass();
    drive_issue(alu_sll, 3'd4, 1'b1, 16'h1111, 3'd0, 1'b0, 16'h0000, 3'd5);
    cdb = '{valid: 1'b1, data: 16'h1234, tag: 3'd5};
    step();
    clear_issue();
    cdb = '0;
    n_compared++;
    if ({disp_valid, disp_b} !== {1'b1, 16'h1234}) begin
      n_mismatched++;
      $display("FAIL bypass: got v=%b b=%h required v=1 b=1234", disp_valid, disp_b);
    end
    push_exp(alu_sll, 16'h1111, 16'h1234, 3'd4);
    fu_ready = 1'b1;
    step();
    fu_ready = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      n_compared++;
      if (issue_ready !== 1'b1) begin
        n_mismatched++;
        $display("FAIL full_fill_%0d: got issue_ready=%b required 1", i, issue_ready);
      end
      drive_issue(lc3b_aluop'(i), 3'(i + 4), 1'b0, 16'h0000, 3'd6, 1'b1, 16'h1000 + 16'(i), 3'd0);
      step();
    end
    clear_issue();
    n_compared++;
    if (issue_ready !== 1'b0) begin
      n_mismatched++;
      $display("FAIL full_not_ready: got issue_ready=%b required 0", issue_ready);
    end
    // held issue while full must be ignored
    drive_issue(alu_pass, 3'd7, 1'b1, 16'hDEAD, 3'd0, 1'b1, 16'hBEEF, 3'd0);
    step();
    clear_issue();
    cdb = '{valid: 1'b1, data: 16'h6666, tag: 3'd6};
    step();
    cdb = '0;
    for (int i = 0; i < 4; i++) begin
      push_exp(lc3b_aluop'(i), 16'h6666, 16'h1000 + 16'(i), 3'(i + 4));
    end
    fu_ready = 1'b1;
    n_compared++;
    if (issue_ready !== 1'b0) begin
      n_mismatched++;
      $display("FAIL full_disp_cycle: got issue_ready=%b required 0", issue_ready);
    end
    step();
    fu_ready = 1'b0;
    n_compared++;
    if (issue_ready !== 1'b1) begin
      n_mismatched++;
      $display("FAIL full_after_disp: got issue_ready=%b required 1", issue_ready);
    end
    fu_ready = 1'b1;
    repeat (3) step();
    fu_ready = 1'b0;
    n_compared++;
    if (disp_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL full_drained: got disp_valid=%b required 0", disp_valid);
    end
  endtask

  task automatic test_age_order();
    // X takes slot 0, A slot 1; after X leaves, B reuses slot 0 but is younger
    drive_issue(alu_add, 3'd1, 1'b1, 16'h0001, 3'd0, 1'b0, 16'h0000, 3'd7);
    step();
    drive_issue(alu_and, 3'd2, 1'b0, 16'h0000, 3'd4, 1'b1, 16'h00A0, 3'd0);
    step();
    clear_issue();
    cdb = '{valid: 1'b1, data: 16'h7777, tag: 3'd7};
    step();
    cdb = '0;
    push_exp(alu_add, 16'h0001, 16'h7777, 3'd1);
    fu_ready = 1'b1;
    step();
    fu_ready = 1'b0;
    drive_issue(alu_not, 3'd3, 1'b0, 16'h0000, 3'd4, 1'b0, 16'h0000, 3'd4);
    step();
    clear_issue();
    cdb = '{valid: 1'b1, data: 16'hBEEF, tag: 3'd4};
    step();
    cdb = '0;
    step();
    n_compared++;
    if ({disp_valid, disp_tag, disp_a} !== {1'b1, 3'd2, 16'hBEEF}) begin
      n_mismatched++;
      $display("FAIL age_oldest_held: got v=%b tag=%0d a=%h required v=1 tag=2 a=beef",
               disp_valid, disp_tag, disp_a);
    end
    push_exp(alu_and, 16'hBEEF, 16'h00A0, 3'd2);
    push_exp(alu_not, 16'hBEEF, 16'hBEEF, 3'd3);
    fu_ready = 1'b1;
    repeat (2) step();
    fu_ready = 1'b0;
    n_compared++;
    if (disp_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL age_drained: got disp_valid=%b required 0", disp_valid);
    end
  endtask

  task automatic test_flush();
    drive_issue(alu_add, 3'd1, 1'b0, 16'h0000, 3'd6, 1'b1, 16'h0001, 3'd0);
    step();
    drive_issue(alu_and, 3'd2, 1'b0, 16'h0000, 3'd6, 1'b1, 16'h0002, 3'd0);
    step();
    drive_issue(alu_pass, 3'd3, 1'b1, 16'h0003, 3'd0, 1'b1, 16'h0004, 3'd0);
    step();
    n_compared++;
    if (disp_valid !== 1'b1) begin
      n_mismatched++;
      $display("FAIL flush_pre_ready: got disp_valid=%b required 1", disp_valid);
    end
    drive_issue(alu_sra, 3'd5, 1'b1, 16'h0055, 3'd0, 1'b1, 16'h0066, 3'd0);
    flush    = 1'b1;
    fu_ready = 1'b1;
    step();
    flush    = 1'b0;
    fu_ready = 1'b0;
    clear_issue();
    n_compared++;
    if ({issue_ready, disp_valid} !== 2'b10) begin
      n_mismatched++;
      $display("FAIL flush_cleared: got issue_ready=%b disp_valid=%b required 1 0",
               issue_ready, disp_valid);
    end
    cdb = '{valid: 1'b1, data: 16'h9999, tag: 3'd6};
    step();
    cdb = '0;
    n_compared++;
    if (disp_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL flush_no_retained: got disp_valid=%b required 0", disp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      drive_issue(alu_add, 3'(i), 1'b0, 16'h0000, 3'd5, 1'b0, 16'h0000, 3'd5);
      step();
    end
    clear_issue();
    n_compared++;
    if (issue_ready !== 1'b0) begin
      n_mismatched++;
      $display("FAIL flush_all_free: got issue_ready=%b required 0 after 4 issues", issue_ready);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    fu_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_compared++;
      if (issue_ready !== 1'b1) begin
        n_mismatched++;
        $display("FAIL b2b_issue_ready_%0d: got %b required 1", i, issue_ready);
      end
      drive_issue(lc3b_aluop'(i), 3'(i), 1'b1, 16'h0100 + 16'(i), 3'd0,
                  1'b1, 16'h0200 + 16'(i * 3), 3'd0);
      push_exp(lc3b_aluop'(i), 16'h0100 + 16'(i), 16'h0200 + 16'(i * 3), 3'(i));
      step();
    end
    clear_issue();
    step();
    fu_ready = 1'b0;
    n_compared++;
    if (disp_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL b2b_drained: got disp_valid=%b required 0", disp_valid);
    end
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    fu_ready = 1'b0;
    cdb      = '0;
    clear_issue();
    test_reset();
    test_basic_add();
    test_cdb_wakeup();
    test_issue_bypass();
    test_full();
    test_age_order();
    test_flush();
    test_back_to_back();
    step();
    n_compared++;
    if (sb.size() !== 0) begin
      n_mismatched++;
      $display("FAIL sb_leftover: got %0d pending dispatches required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
